// File: rtl/imld_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, default
// load address and the byte-lane geometry of one 32-bit word.
package imld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } imld_state_e;

    localparam logic [31:0] IMLD_BASE_ADDR = 32'h0000_3000;
    localparam int unsigned IMLD_LANES     = 4;
    localparam int unsigned IMLD_LANE_W    = $clog2(IMLD_LANES);

    // Byte address of a word index; wraps modulo 2^32 by construction.
    function automatic logic [31:0] imld_word_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imld_packer.sv
// Big-endian byte-to-word packer: first byte lands in bits 31:24. A word is
// presented (combinationally) on the 4th byte or early on last, zero-padded.
module imld_packer
    import imld_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [IMLD_LANE_W-1:0] lane_q, lane_d;
    logic [31:0]            acc_q, acc_d;
    logic [4:0]             shift_amt;
    logic                   lane_last;

    always_comb begin
        shift_amt    = {IMLD_LANE_W'(IMLD_LANES - 1) - lane_q, 3'b000};
        lane_last    = (lane_q == IMLD_LANE_W'(IMLD_LANES - 1));
        word_o       = acc_q | (32'(byte_i) << shift_amt);
        word_valid_o = byte_valid_i & (lane_last | last_i);

        lane_d = lane_q;
        acc_d  = acc_q;
        if (clear_i) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (byte_valid_i) begin
            if (word_valid_o) begin
                lane_d = '0;
                acc_d  = '0;
            end else begin
                lane_d = lane_q + 1'b1;
                acc_d  = word_o;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory, zero-fills the rest and holds
// the CPU meanwhile. Define IMLD_CHECKSUM_EN to get a running image checksum.
module imem_loader
    import imld_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = IMLD_BASE_ADDR
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        ovf,
    output logic [31:0] checksum
);

    localparam int unsigned         IDX_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]    IDX_END  = IDX_W'(DEPTH);

    imld_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              full;
    logic              pk_clear;
    logic              pk_valid;
    logic              pk_word_valid;
    logic [31:0]       pk_word;
    logic              img_write;

    imld_packer u_packer (
        .clk          (clk),
        .clr_n        (clr_n),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (in_data),
        .last_i       (in_last),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    assign in_ready = (state_q == ST_LOAD);
    assign cpu_hold = (state_q == ST_LOAD) || (state_q == ST_FILL);
    assign done     = (state_q == ST_DONE);
    assign accept   = in_valid & in_ready;
    assign full     = (idx_q == IDX_END);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        ovf_d     = ovf_q;
        pk_clear  = 1'b0;
        pk_valid  = 1'b0;
        img_write = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    idx_d    = '0;
                    ovf_d    = 1'b0;
                    pk_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                // Once memory is full, bytes are still drained but dropped.
                pk_valid = accept & ~full;
                if (accept && full) begin
                    ovf_d = 1'b1;
                end
                if (pk_word_valid) begin
                    we_d      = 1'b1;
                    waddr_d   = imld_word_addr(BASE_ADDR, 32'(idx_q));
                    wdata_d   = pk_word;
                    idx_d     = idx_q + 1'b1;
                    img_write = 1'b1;
                end
                if (accept && in_last) begin
                    if (full || (pk_word_valid && (idx_q == IDX_LAST))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                we_d    = 1'b1;
                waddr_d = imld_word_addr(BASE_ADDR, 32'(idx_q));
                wdata_d = 32'h0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= 32'h0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign ovf   = ovf_q;

`ifdef IMLD_CHECKSUM_EN
    logic [31:0] csum_q;

    // Updated in the same edge that raises we, so it tracks the written words.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            csum_q <= 32'h0;
        end else if (pk_clear) begin
            csum_q <= 32'h0;
        end else if (img_write) begin
            csum_q <= csum_q + pk_word;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: instruction-memory size in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00003000: byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin load session (pulse).
REQ-006 SHALL have port in_valid  input  1  byte available on in_data.
REQ-007 SHALL have port in_data  input  8  image byte, big-endian order (first byte = bits 31:24).
REQ-008 SHALL have port in_last  input  1  qualifies final byte of the image.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port we  output  1  one-cycle write strobe to instruction memory.
REQ-011 SHALL have port waddr  output  32  byte address = BASE_ADDR + 4*word_index.
REQ-012 SHALL have port wdata  output  32  word written.
REQ-013 SHALL have port cpu_hold  output  1  keeps the fetch PC frozen while loading.
REQ-014 SHALL have port done  output  1  image fully written.
REQ-015 SHALL have port ovf  output  1  bytes arrived beyond DEPTH words.
REQ-016 SHALL have port checksum  output  32  sum of written words (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE -> LOAD (start) -> FILL (last byte accepted) -> DONE (word DEPTH-1 written); DONE -> LOAD on start.
REQ-018 SHALL ignore start in LOAD and FILL.
REQ-019 SHALL drive in_ready=1 only in LOAD; byte transfer = in_valid & in_ready.
REQ-020 SHALL pack 4 accepted bytes into one word; we/waddr/wdata registered, asserted the cycle after the 4th byte.
REQ-021 SHALL, when in_last arrives mid-word, zero-pad remaining low bytes and write that partial word.
REQ-022 SHALL increment word_index by 1 per write, starting at 0 on each start.
REQ-023 SHALL, after the image, write 32'h0 to every remaining index up to DEPTH-1, one per cycle in FILL.
REQ-024 SHALL, once word_index reaches DEPTH in LOAD, keep in_ready=1, discard bytes, set ovf, suppress we; FILL is then skipped.
REQ-025 SHALL hold cpu_hold=1 in LOAD and FILL, 0 in IDLE and DONE.
REQ-026 SHALL hold done=1 only in DONE; done and ovf clear on start.
REQ-027 SHALL compute waddr modulo 2^32 (no saturation).

Reset
REQ-028 SHALL on clr_n=0 immediately force IDLE, word_index=0, byte lane=0, in_ready=0, we=0, waddr=BASE_ADDR, wdata=0, cpu_hold=0, done=0, ovf=0, checksum=0.
REQ-029 SHALL abandon a load in progress on reset with no further writes; no partial-word flush.

Configuration
REQ-030 SHALL, with IMLD_CHECKSUM_EN defined, accumulate checksum += wdata (mod 2^32) per image write, excluding FILL zeros, clearing on start.
REQ-031 SHALL, without IMLD_CHECKSUM_EN, tie checksum to 32'h0 with no accumulator logic.

Structure
REQ-032 SHALL place FSM state enum, default BASE_ADDR and byte-lane count constant in shared package imld_pkg.
REQ-033 SHALL place byte-to-word assembly (lane counter, shift register, pad-on-last) in sub-module imld_packer.

Verification
REQ-034 SHALL cover: start, bytes 8C 01 00 04 (last on 4th) -> one we, waddr=32'h00003000, wdata=32'h8C010004, then DEPTH-1 zero writes, done=1.
REQ-035 SHALL cover: 6 bytes 11 22 33 44 55 66, last on 6th -> writes 32'h11223344 @3000, 32'h55660000 @3004.
REQ-036 SHALL cover: DEPTH=4, 20 bytes -> 4 writes, ovf=1, no FILL, done=1.
REQ-037 SHALL cover: clr_n low after 2 bytes -> we never asserts, cpu_hold=0, state IDLE.
REQ-038 SHALL cover: in_valid toggling every other cycle and start during LOAD -> identical write sequence, start ignored.
REQ-039 SHALL cover with IMLD_CHECKSUM_EN: words 32'hFFFFFFFF, 32'h00000002 -> checksum=32'h00000001.
